// File: rtl/alu_rf_pkg.sv
// rtl/alu_rf_pkg.sv - opcodes, status bit positions and FSM states for alu_rf_seq
package alu_rf_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADC  = 4'd1,
    OP_SUB  = 4'd2,
    OP_SBB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NOT  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_ASR  = 4'd10,
    OP_ROL  = 4'd11,
    OP_CMP  = 4'd12,
    OP_LOAD = 4'd13,
    OP_MUL  = 4'd14,
    OP_DIVU = 4'd15
  } op_e;

  // Bit positions inside the status word
  localparam int ST_Z    = 0;
  localparam int ST_C    = 1;
  localparam int ST_N    = 2;
  localparam int ST_V    = 3;
  localparam int ST_EQ   = 4;
  localparam int ST_GT   = 5;
  localparam int ST_LT   = 6;
  localparam int ST_BITS = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_WB   = 2'd3
  } state_e;

  // Ops that run through the multi-cycle multiply/divide engine
  function automatic logic is_iterative(input op_e o);
    return (o == OP_MUL) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// rtl/alu_iter_muldiv.sv - shared shift/accumulate engine for unsigned multiply and restoring divide
module alu_iter_muldiv
  import alu_rf_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             is_div,
  input  logic             step,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             finish,
  output logic             mode_div,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  // acc is the running high half (product high / partial remainder),
  // q holds multiplier bits being consumed or quotient bits being formed.
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] opb_q;
  logic [CW-1:0]    iter_cnt;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   trial_rem;
  logic [WIDTH:0]   trial_diff;
  logic             fits;

  // One iteration of shift-add (multiply) and of restoring divide
  always_comb begin
    add_sum    = {1'b0, acc} + (q[0] ? {1'b0, opb_q} : '0);
    trial_rem  = {acc, q[WIDTH-1]};
    trial_diff = trial_rem - {1'b0, opb_q};
    fits       = (trial_rem >= {1'b0, opb_q});
  end

  // Operand load on start, then one iteration per step; a zero divisor
  // naturally yields all-ones quotient and remainder = dividend.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc      <= '0;
      q        <= '0;
      opb_q    <= '0;
      iter_cnt <= '0;
      mode_div <= 1'b0;
    end else if (start) begin
      acc      <= '0;
      q        <= op_a;
      opb_q    <= op_b;
      iter_cnt <= '0;
      mode_div <= is_div;
    end else if (step) begin
      iter_cnt <= iter_cnt + 1'b1;
      if (mode_div) begin
        if (fits) begin
          acc <= trial_diff[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], 1'b1};
        end else begin
          acc <= trial_rem[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc <= add_sum[WIDTH:1];
        q   <= {add_sum[0], q[WIDTH-1:1]};
      end
    end
  end

  assign finish = step && (iter_cnt == CW'(WIDTH - 1));
  assign res_lo = q;
  assign res_hi = acc;

endmodule

// File: rtl/alu_rf_seq.sv
// rtl/alu_rf_seq.sv - register-file ALU with handshake, flags and iterative multiply/divide
module alu_rf_seq
  import alu_rf_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int RIDX = $clog2(NREGS),
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [RIDX-1:0]    src1,
  input  logic [RIDX-1:0]    src2,
  input  logic [RIDX-1:0]    dst,
  input  logic               use_imm,
  input  logic [WIDTH-1:0]   imm,
  output logic               ready,
  output logic               done,
  input  logic [RIDX-1:0]    rd_idx,
  output logic [WIDTH-1:0]   rd_data,
  output logic [ST_BITS-1:0] status
);

  logic [WIDTH-1:0]   regs [NREGS];
  state_e             state;
  state_e             state_nx;
  op_e                opc;
  logic [WIDTH-1:0]   op1;
  logic [WIDTH-1:0]   op2;
  logic               accept;
  logic               iter_go;
  logic [SHW-1:0]     amt;
  logic               cin;
  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic [WIDTH:0]     shl_full;
  logic [WIDTH:0]     shr_full;
  logic [WIDTH:0]     asr_full;
  logic [WIDTH-1:0]   rol_res;
  logic [WIDTH-1:0]   res;
  logic               wr_en;
  logic               flags_en;
  logic               c_nx;
  logic               v_nx;
  logic [ST_BITS-1:0] st_nx;
  logic [ST_BITS-1:0] wb_status;
  logic [RIDX-1:0]    wb_dst;
  logic [RIDX-1:0]    wb_pair;
  logic               div0_q;
  logic               md_finish;
  logic               md_mode_div;
  logic [WIDTH-1:0]   md_lo;
  logic [WIDTH-1:0]   md_hi;

  assign opc     = op_e'(op);
  assign op1     = regs[src1];
  assign op2     = use_imm ? imm : regs[src2];
  assign ready   = (state == S_IDLE);
  assign accept  = start && ready;
  assign iter_go = is_iterative(opc);
  assign amt     = op2[SHW-1:0];
  assign rd_data = regs[rd_idx];
  assign wb_pair = wb_dst + 1'b1;

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (accept && iter_go),
    .is_div   (opc == OP_DIVU),
    .step     ((state == S_MUL) || (state == S_DIV)),
    .op_a     (op1),
    .op_b     (op2),
    .finish   (md_finish),
    .mode_div (md_mode_div),
    .res_lo   (md_lo),
    .res_hi   (md_hi)
  );

  // Wide arithmetic and shift candidates; the extra bit carries C out
  always_comb begin
    cin      = ((opc == OP_ADC) || (opc == OP_SBB)) ? status[ST_C] : 1'b0;
    add_full = {1'b0, op1} + {1'b0, op2} + {{WIDTH{1'b0}}, cin};
    sub_full = {1'b0, op1} - {1'b0, op2} - {{WIDTH{1'b0}}, cin};
    shl_full = {1'b0, op1} << amt;
    shr_full = {op1, 1'b0} >> amt;
    asr_full = $unsigned($signed({op1, 1'b0}) >>> amt);
    rol_res  = (op1 << amt) | (op1 >> (WIDTH - 32'(amt)));
  end

  // Result word, write enable and next status for single-cycle ops
  always_comb begin
    res      = '0;
    wr_en    = 1'b0;
    flags_en = 1'b0;
    c_nx     = 1'b0;
    v_nx     = 1'b0;
    st_nx    = status;
    case (opc)
      OP_ADD, OP_ADC: begin
        res      = add_full[WIDTH-1:0];
        c_nx     = add_full[WIDTH];
        v_nx     = (op1[WIDTH-1] == op2[WIDTH-1]) && (res[WIDTH-1] != op1[WIDTH-1]);
        wr_en    = 1'b1;
        flags_en = 1'b1;
      end
      OP_SUB, OP_SBB: begin
        res      = sub_full[WIDTH-1:0];
        c_nx     = sub_full[WIDTH];
        v_nx     = (op1[WIDTH-1] != op2[WIDTH-1]) && (res[WIDTH-1] != op1[WIDTH-1]);
        wr_en    = 1'b1;
        flags_en = 1'b1;
      end
      OP_AND: begin res = op1 & op2; wr_en = 1'b1; flags_en = 1'b1; end
      OP_OR:  begin res = op1 | op2; wr_en = 1'b1; flags_en = 1'b1; end
      OP_XOR: begin res = op1 ^ op2; wr_en = 1'b1; flags_en = 1'b1; end
      OP_NOT: begin res = ~op2;      wr_en = 1'b1; flags_en = 1'b1; end
      OP_SHL: begin
        res      = shl_full[WIDTH-1:0];
        c_nx     = shl_full[WIDTH];
        wr_en    = 1'b1;
        flags_en = 1'b1;
      end
      OP_SHR: begin
        res      = shr_full[WIDTH:1];
        c_nx     = shr_full[0];
        wr_en    = 1'b1;
        flags_en = 1'b1;
      end
      OP_ASR: begin
        res      = asr_full[WIDTH:1];
        c_nx     = asr_full[0];
        wr_en    = 1'b1;
        flags_en = 1'b1;
      end
      OP_ROL: begin
        // The bit rotated into position 0 is the last one shifted out
        res      = rol_res;
        c_nx     = (amt != '0) && rol_res[0];
        wr_en    = 1'b1;
        flags_en = 1'b1;
      end
      OP_CMP: begin
        st_nx[ST_EQ] = (op1 == op2);
        st_nx[ST_GT] = (op1 > op2);
        st_nx[ST_LT] = (op1 < op2);
      end
      OP_LOAD: begin
        res   = op2;
        wr_en = 1'b1;
      end
      default: ;
    endcase
    if (flags_en) begin
      st_nx[ST_Z] = (res == '0);
      st_nx[ST_N] = res[WIDTH-1];
      st_nx[ST_C] = c_nx;
      st_nx[ST_V] = v_nx;
    end
  end

  // Flags for the multiply/divide writeback; compare flags are kept
  always_comb begin
    wb_status       = status;
    wb_status[ST_Z] = (md_lo == '0);
    wb_status[ST_N] = md_lo[WIDTH-1];
    wb_status[ST_C] = 1'b0;
    wb_status[ST_V] = md_mode_div ? div0_q : (md_hi != '0);
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nx;
  end

  // FSM next state: iterate WIDTH edges, then one writeback edge
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept && (opc == OP_MUL))       state_nx = S_MUL;
        else if (accept && (opc == OP_DIVU)) state_nx = S_DIV;
      end
      S_MUL, S_DIV: if (md_finish) state_nx = S_WB;
      S_WB:         state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  // Register file, status and done pulse; single-cycle writes and the
  // pair writeback never coincide because ready is low outside IDLE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      status <= '0;
      done   <= 1'b0;
      wb_dst <= '0;
      div0_q <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && !iter_go) begin
        if (wr_en) regs[dst] <= res;
        status <= st_nx;
        done   <= 1'b1;
      end
      if (accept && iter_go) begin
        wb_dst <= dst;
        div0_q <= (op2 == '0);
      end
      if (state == S_WB) begin
        regs[wb_dst]  <= md_lo;
        regs[wb_pair] <= md_hi;
        status        <= wb_status;
        done          <= 1'b1;
      end
    end
  end

endmodule

// File: doc/alu_rf_seq.md
Name: alu_rf_seq

Overview:
- Parametrised successor to the current 16-bit, 8-register ALU.
- Adds configurable data width and register count, a ready/start/done handshake, carry-chained arithmetic, arithmetic shift and rotate, signed-overflow and compare flags, and iterative multiply and unsigned divide that write a double-width result into a register pair.
- Sits between the instruction decoder (start/op/indices) and the data bus (imm/rd_data).

Parameters:
- WIDTH, 16, datapath and register width; power of two, >= 8.
- NREGS, 8, number of general registers; power of two, >= 2.
- Derived localparams (not overridable): RIDX = clog2(NREGS), SHW = clog2(WIDTH).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  request; accepted on an edge where start && ready.
- op  in  4  operation code (package enum).
- src1  in  RIDX  operand-1 register index.
- src2  in  RIDX  operand-2 register index.
- dst  in  RIDX  result register index.
- use_imm  in  1  operand2 = imm instead of reg[src2].
- imm  in  WIDTH  immediate / bus data.
- ready  out  1  high when idle and able to accept.
- done  out  1  one-cycle pulse after result and flags are written.
- rd_idx  in  RIDX  debug/bus read index.
- rd_data  out  WIDTH  combinational reg[rd_idx].
- status  out  7  {SLT, LT, GT, EQ, V, N, C, Z}[6:0]; Z at bit 0. (SLT folded: bits are Z, C, N, V, EQ, GT, LT; signed-less-than is not provided.)

Behaviour:
- Reset (async, while RST_N = 0):
  - all registers = 0, status = 0, state = IDLE, ready = 1, done = 0.
  - An in-flight iterative op is discarded and produces no done.
- Operand capture: op1 = reg[src1]; op2 = use_imm ? imm : reg[src2], both sampled at the accept edge. Iterative ops work on latched copies.
- Single-cycle ops (ADD, ADC, SUB, SBB, AND, OR, XOR, NOT, SHL, SHR, ASR, ROL, CMP, LOAD):
  - dst and flags are written on the accept edge.
  - done = 1 for the following cycle only; ready stays 1, so back-to-back accepts are allowed every cycle.
- Arithmetic:
  - ADD/SUB use a WIDTH+1 result; ADC/SBB also add or subtract the stored C.
  - C = carry out (for SUB/SBB, C = borrow).
  - V = signed overflow.
- Logic ops: NOT = ~op2; C = 0, V = 0.
- Shifts:
  - amount = op2[SHW-1:0].
  - C = last bit shifted out; with amount 0 the result is op1 and C = 0.
  - ASR replicates the msb; ROL rotates left. V = 0.
- Z and N are computed from the written word for every op except CMP and LOAD.
- CMP: updates EQ/GT/LT (unsigned op1 vs op2) only; Z, C, N, V and the registers are unchanged.
- LOAD: dst = op2; all flags unchanged.
- FSM states: IDLE, MUL, DIV, WB.
  - IDLE -> MUL/DIV on accepting MUL/DIVU; ready drops on the next cycle.
  - MUL/DIV: exactly WIDTH iteration edges (shift-add; restoring divide), then -> WB.
  - WB: writes the pair, sets flags, -> IDLE, done = 1 next cycle, ready = 1.
  - Latency from accept to writeback edge: WIDTH+1 edges.
- MUL: reg[dst] = product low, reg[(dst+1) mod NREGS] = product high.
  - Z from the low half; V = (high != 0); C = 0.
- DIVU: reg[dst] = quotient, reg[(dst+1) mod NREGS] = remainder.
  - Divide by zero: quotient = all ones, remainder = dividend, V = 1.
  - Otherwise V = 0; C = 0.
- Register-index rules:
  - Pair index wraps: dst = NREGS-1 pairs with reg 0.
  - src == dst is legal; operands are sampled before the write.
- start while busy is ignored. It is not queued; the requester must hold start until ready.
- Undefined op codes: no register or flag change, but done still pulses (acts as NOP).

Decomposition:
- Package alu_rf_pkg holds:
  - op enum: ADD=0, ADC, SUB, SBB, AND, OR, XOR, NOT, SHL, SHR, ASR, ROL, CMP, LOAD, MUL, DIVU=15;
  - status bit-position constants;
  - FSM state enum.
- Sub-module alu_iter_muldiv: shared shift register/accumulator for MUL and DIVU, with start/iter-count/finish interface, parametrised by WIDTH.

Test Plan (WIDTH = 16, NREGS = 8):
1. Reset release -> all reg reads 0, status = 0, ready = 1, done = 0.
2. LOAD r0 = 0xFFFF; then ADD r1 = r0 + imm 1 -> r1 = 0x0000, Z = 1, C = 1, N = 0, V = 0. Then ADC r2 = r1 + imm 0 -> r2 = 0x0001. One done pulse per op, back-to-back.
3. MUL r7 = 0x1234 * imm 0x0100 -> r7 = 0x3400, r0 = 0x0012 (wrap), V = 1. done exactly 17 edges after accept; ready = 0 throughout; start pulses mid-op cause no effect.
4. DIVU r2 = 100 / imm 7 -> r2 = 14, r3 = 2, V = 0. DIVU by imm 0 -> r2 = 0xFFFF, r3 = 100, V = 1.
5. Shifts and CMP on r4 = 0x8001:
   - SHR 1 -> 0x4000, C = 1.
   - ASR 1 -> 0xC000, N = 1.
   - ROL 4 -> 0x0018.
   - SHL 0 -> 0x8001, C = 0.
   - CMP 3 vs 5 -> LT = 1, GT = 0, EQ = 0; Z, C, N, V unchanged.
6. RST_N low 5 cycles into a MUL -> registers and status cleared immediately. No done pulse; ready = 1 after release; next ADD completes normally.
